// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester arbiter driving a shared 16-bit mux into a one-entry output register
// Define MUX_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mux_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_reset_n,
  input  logic             in_req0,
  input  logic [WIDTH-1:0] in_data0,
  output logic             out_ack0,
  input  logic             in_req1,
  input  logic [WIDTH-1:0] in_data1,
  output logic             out_ack1,
  output logic             out_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             in_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             elig0, elig1, load, winner;

  // A requester is masked during its own ack cycle so a held request is not captured twice.
  assign elig0 = in_req0 & ~ack0_q;
  assign elig1 = in_req1 & ~ack1_q;
  assign load  = ((state_q == EMPTY) | in_ready) & (elig0 | elig1);

`ifdef MUX_ARB_FIXED_PRI_EN
  assign winner  = ~elig0 & elig1;
  assign out_sel = winner;
`else
  logic last_q, last_d;

  assign winner  = (elig0 & elig1) ? ~last_q : elig1;
  // Idle with nothing pending parks the select at 0; otherwise it follows the last grant.
  assign out_sel = load ? winner : ((in_req0 | in_req1) & last_q);
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifndef MUX_ARB_FIXED_PRI_EN
    last_d  = last_q;
`endif
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)          state_d = FULL;
        else if (in_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      data_d = winner ? in_data1 : in_data0;
      ack0_d = ~winner;
      ack1_d = winner;
`ifndef MUX_ARB_FIXED_PRI_EN
      last_d = winner;
`endif
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifndef MUX_ARB_FIXED_PRI_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifndef MUX_ARB_FIXED_PRI_EN
      last_q  <= last_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ack0  = ack0_q;
  assign out_ack1  = ack1_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed and randomized check of mux_arbiter against a behavioural model
module tb_mux_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, ready = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         ack0, ack1, sel, valid;
  logic [W-1:0] data;
  int           n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(W)) dut (
    .in_clk(clk), .in_reset_n(rst_n),
    .in_req0(req0), .in_data0(d0), .out_ack0(ack0),
    .in_req1(req1), .in_data1(d1), .out_ack1(ack1),
    .out_sel(sel), .out_valid(valid), .out_data(data),
    .in_ready(ready)
  );

`ifdef MUX_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // Model state: what the output register, acks and grant history must be.
  logic         m_valid, m_ack0, m_ack1, m_last;
  logic [W-1:0] m_data;

  function automatic logic pick(bit e0, bit e1);
    if (e0 && e1) return FIXED ? 1'b0 : ~m_last;
    return e1;
  endfunction

  function automatic logic exp_sel();
    bit e0 = req0 && !m_ack0;
    bit e1 = req1 && !m_ack1;
    bit go = (!m_valid || ready) && (e0 || e1);
    if (FIXED) return e1 && !e0;
    if (go) return pick(e0, e1);
    if (!(req0 || req1)) return 1'b0;
    return m_last;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit e0, e1, w;
    if (!rst_n) begin
      m_valid <= 1'b0; m_data <= '0; m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_last <= 1'b1;
    end else begin
      e0 = req0 && !m_ack0;
      e1 = req1 && !m_ack1;
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
      if ((!m_valid || ready) && (e0 || e1)) begin
        w = pick(e0, e1);
        m_data  <= w ? d1 : d0;
        m_valid <= 1'b1;
        if (w) m_ack1 <= 1'b1; else m_ack0 <= 1'b1;
        m_last  <= w;
      end else if (ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_valid", {31'b0, valid}, {31'b0, m_valid});
    chk("m_data",  {16'b0, data},  {16'b0, m_data});
    chk("m_ack0",  {31'b0, ack0},  {31'b0, m_ack0});
    chk("m_ack1",  {31'b0, ack1},  {31'b0, m_ack1});
    chk("m_sel",   {31'b0, sel},   {31'b0, exp_sel()});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0); chk("rst_data", data, 0);
    chk("rst_ack0", ack0, 0);   chk("rst_ack1", ack1, 0); chk("rst_sel", sel, 0);
    cyc();
    rst_n = 1'b1;

    // single requester
    req0 = 1'b1; d0 = 16'h0001; ready = 1'b1;
    cyc();
    chk("single_valid", valid, 1); chk("single_data", data, 16'h0001);
    chk("single_ack0", ack0, 1);   chk("single_ack1", ack1, 0); chk("single_sel", sel, 0);
    req0 = 1'b0;
    cyc();
    chk("single_ack0_pulse", ack0, 0); chk("single_drain", valid, 0);

    // tie from reset, then a real tie after a stall
    rst_n = 1'b0;
    #1 chk("rst_async_valid", valid, 0);
    rst_n = 1'b1;
    req0 = 1'b1; d0 = 16'h00AA; req1 = 1'b1; d1 = 16'h0055;
    cyc();
    chk("tie_first", data, 16'h00AA); chk("tie_first_ack0", ack0, 1); chk("tie_first_ack1", ack1, 0);
    ready = 1'b0;
    cyc();
    chk("stall_data", data, 16'h00AA); chk("stall_ack0", ack0, 0); chk("stall_sel", sel, 0);
    ready = 1'b1;
    #1 chk("tie2_sel", sel, FIXED ? 0 : 1);
    cyc();
    chk("tie2_data", data, FIXED ? 16'h00AA : 16'h0055); chk("tie2_ack1", ack1, FIXED ? 0 : 1);
    cyc();
    chk("tie3_data", data, FIXED ? 16'h0055 : 16'h00AA); chk("tie3_ack0", ack0, FIXED ? 0 : 1);
    req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();

    // backpressure
    req0 = 1'b1; d0 = 16'h1234;
    cyc();
    chk("bp_load", data, 16'h1234);
    req0 = 1'b0; ready = 1'b0; req1 = 1'b1; d1 = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_data", data, 16'h1234); chk("bp_hold_ack1", ack1, 0); chk("bp_hold_valid", valid, 1);
    end
    ready = 1'b1;
    cyc();
    chk("bp_release_data", data, 16'hBEEF); chk("bp_release_ack1", ack1, 1);
    req1 = 1'b0;
    cyc();

    // back-to-back stream from requester 1, ending in a drain
    req1 = 1'b1; d1 = 16'h0001;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("b2b_data", data, i); chk("b2b_ack1", ack1, 1); chk("b2b_valid", valid, 1);
      if (i < 3) d1 = W'(i + 1); else req1 = 1'b0;
      cyc();
      chk("b2b_gap_valid", valid, 0); chk("b2b_gap_ack1", ack1, 0); chk("b2b_gap_data", data, i);
    end

    // reset mid-transfer while FULL
    req0 = 1'b1; d0 = 16'h7777;
    cyc();
    chk("mid_full", valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0); chk("mid_rst_data", data, 0); chk("mid_rst_ack0", ack0, 0);
    req0 = 1'b0;
    cyc();
    rst_n = 1'b1;

    // randomized traffic obeying the hold-until-ack protocol
    for (int n = 0; n < 3000; n++) begin
      if (m_ack0) begin
        req0 = 1'($urandom_range(0, 1)); d0 = W'($urandom);
      end else if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; d0 = W'($urandom);
      end
      if (m_ack1) begin
        req1 = 1'($urandom_range(0, 1)); d1 = W'($urandom);
      end else if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; d1 = W'($urandom);
      end
      ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter sharing the 16-bit two-input result mux between two requesters. Each cycle the block picks one pending requester and drives the mux select. It captures the selected word into a single-entry output register and returns a one-cycle acknowledge to the winner. It sits between two producer units and the downstream consumer of the mux result, replacing a statically driven select line.

## Interface
- `WIDTH`, 16, data width of each requester and of the output register.
- `in_clk`  input  1  clock; all state changes on the rising edge.
- `in_reset_n`  input  1  asynchronous, active-low reset.
- `in_req0`  input  1  requester 0 has a word pending.
- `in_data0`  input  WIDTH  requester 0 word; mux input 0.
- `out_ack0`  output  1  one-cycle pulse: requester 0 word captured.
- `in_req1`  input  1  requester 1 has a word pending.
- `in_data1`  input  WIDTH  requester 1 word; mux input 1.
- `out_ack1`  output  1  one-cycle pulse: requester 1 word captured.
- `out_sel`  output  1  mux select for the current arbitration decision (combinational).
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  output register contents.
- `in_ready`  input  1  consumer accepts `out_data` this cycle.

## Operation
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY to FULL on a load.
  - FULL to EMPTY when `in_ready`=1 and there is no load.
  - FULL stays FULL when `in_ready`=1 and a load occurs in the same cycle.
- Eligible requester N: `in_reqN`=1 and `out_ackN`=0. A requester is masked during its own ack cycle.
- Load condition: (EMPTY or `in_ready`=1) and at least one requester is eligible.
- Arbitration:
  - Only one eligible requester: it wins.
  - Both eligible: the one not granted last wins.
  - `last` pointer updates only on a load.
- `out_sel` = index of the current winner. When no load occurs, it holds `last`.
- On a load:
  - `out_data` <= `in_dataN` through the mux.
  - `out_valid` <= 1.
  - `out_ackN` <= 1 for exactly one cycle.
  - `last` <= N.
- Requester protocol:
  - `in_reqN` and `in_dataN` are held stable until the ack is seen.
  - A requester may re-assert in the cycle after the ack.
- FULL with `in_ready`=0: register and pointer hold, no ack is issued.
- Unlike widths are not allowed; all data paths are WIDTH bits with no extension.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ack0`=0, `out_ack1`=0.
  - `last`=1, so requester 0 wins the first tie.
  - `out_sel`=0 when no requests are pending.
- Latency: a request seen at edge E (eligible, load condition true) gives `out_valid`=1 and `out_ackN`=1 in the cycle after E.
- Throughput: with `in_ready` held at 1, one word per cycle. Both requesters continuously requesting alternate 0,1,0,1 after their ack masks clear.
- Simultaneous drain and load: a word is accepted and a new word captured on the same edge, with no bubble.
- Reset asserted mid-operation: all outputs clear immediately, independent of the clock, and the pending word is dropped. The first edge after deassertion behaves as post-reset.

## Configuration
- `MUX_ARB_FIXED_PRI_EN` defined: fixed priority; requester 0 always wins a tie. The `last` pointer is not implemented, and `out_sel` = 0 whenever requester 0 is eligible.
- `MUX_ARB_FIXED_PRI_EN` undefined (default): round-robin as described above.

## Test plan
- Reset: hold `in_reset_n`=0 mid-transfer with `out_valid`=1. Required: `out_valid`, `out_data`, and both acks go to 0 immediately, with no clock edge.
- Single requester:
  - Stimulus: `in_req0`=1, `in_data0`=16'h0001, `in_ready`=1.
  - Required, cycle after the edge: `out_valid`=1, `out_data`=16'h0001, `out_ack0`=1 for exactly one cycle, `out_sel`=0.
- Tie from reset:
  - Stimulus: both requesting, `in_data0`=16'h00AA, `in_data1`=16'h0055, `in_ready`=1.
  - Required sequence: 16'h00AA then 16'h0055.
  - Acks alternate ack0 then ack1.
  - With the macro defined: 16'h00AA wins every tie.
- Backpressure:
  - Stimulus: `in_ready`=0 while FULL with 16'h1234, `in_req1`=1.
  - Required: `out_data` holds 16'h1234 and `out_ack1` stays 0 for 3 cycles.
  - On `in_ready`=1, the next cycle shows requester 1's word and `out_ack1`=1.
- Back-to-back: `in_ready`=1 and requester 1 streams 16'h0001, 16'h0002, 16'h0003, re-asserting after each ack. Required: each word appears once, in order, with one idle cycle between words due to the ack mask.
- Drain to empty: FULL, no requests, `in_ready`=1. Required: `out_valid`=0 the next cycle and `out_data` unchanged.
